bool_slice_unit: RTL and testbench



---
 rtl/bool_slice_unit.sv | 133 +++++++++++++
 tb/tb_bool_slice_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bool_slice_unit.sv
// bool_slice_unit: sliced multi-cycle boolean unit; define BOOL_SLICE_FLAGS_EN for zero/parity flags
module bool_slice_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);
  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (SLICE == 0 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("bool_slice_unit: WIDTH must be a nonzero multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SLICE-1:0]  sa, sb, sf;
  logic              accept, last;

  always_comb begin
    accept = in_valid && state_q == IDLE;
    last   = cnt_q == LAST;
    sa     = a_q[int'(cnt_q)*SLICE +: SLICE];
    sb     = b_q[int'(cnt_q)*SLICE +: SLICE];
    case (op_q)
      3'b000:  sf = sa & sb;
      3'b001:  sf = sa | sb;
      3'b010:  sf = sa ^ sb;
      3'b011:  sf = ~(sa & sb);
      3'b100:  sf = ~(sa | sb);
      3'b101:  sf = ~(sa ^ sb);
      3'b110:  sf = sa & ~sb;
      default: sf = ~sa;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b;
        op_d    = op;
        cnt_d   = '0;
        res_d   = '0;
      end
      RUN: begin
        res_d[int'(cnt_q)*SLICE +: SLICE] = sf;
        state_d = last ? DONE : RUN;
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = res_q;

`ifdef BOOL_SLICE_FLAGS_EN
  logic zero_q, zero_d, par_q, par_d;

  // Flags are taken from res_d so the final slice is included on the edge into DONE
  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (accept) begin
      zero_d = 1'b0;
      par_d  = 1'b0;
    end else if (state_q == RUN && last) begin
      zero_d = ~|res_d;
      par_d  = ^res_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign zero   = zero_q;
  assign parity = par_q;
`else
  assign zero   = 1'b0;
  assign parity = 1'b0;
`endif
endmodule

// File: tb/tb_bool_slice_unit.sv
// tb_bool_slice_unit: scoreboard bench for bool_slice_unit at 32/8, 64/16 and 32/32
module tb_bool_slice_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero, parity;
  logic [31:0] a = '0, b = '0, result;
  logic [2:0]  op = '0;

  logic        v2 = 1'b0, rdy2, ov2, z2, p2;
  logic [63:0] a2 = '0, b2 = '0, r2;
  logic [2:0]  op2 = '0;
  logic        v3 = 1'b0, rdy3, ov3, z3, p3;
  logic [31:0] a3 = '0, b3 = '0, r3;
  logic [2:0]  op3 = '0;
  logic        one = 1'b1;

  bool_slice_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .parity(parity));
  bool_slice_unit #(.WIDTH(64), .SLICE(16)) u64 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .a(a2), .b(b2), .op(op2),
    .out_valid(ov2), .out_ready(one), .result(r2), .zero(z2), .parity(p2));
  bool_slice_unit #(.WIDTH(32), .SLICE(32)) u32w (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3), .a(a3), .b(b3), .op(op3),
    .out_valid(ov3), .out_ready(one), .result(r3), .zero(z3), .parity(p3));

  typedef struct {
    logic [31:0] a, b, r;
    logic [2:0]  op;
    logic        z, p;
    int          acc;
  } exp_t;
  typedef struct {
    logic [63:0] r;
    logic        z, p;
    int          acc;
  } exp_w_t;

  exp_t   q[$];
  exp_w_t q2[$], q3[$];
  exp_t   m_e;
  exp_w_t m2, m3;

  logic        or_rand = 1'b0, or_force = 1'b1, seen = 1'b0;
  logic [31:0] held = '0;

  function automatic logic [63:0] ref_f(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return ~x;
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready=%b expected 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    op = iop;
    e.a = ia;
    e.b = ib;
    e.op = iop;
    e.r = 32'(ref_f(iop, {32'd0, ia}, {32'd0, ib}));
`ifdef BOOL_SLICE_FLAGS_EN
    e.z = ~|e.r;
    e.p = ^e.r;
`else
    e.z = 1'b0;
    e.p = 1'b0;
`endif
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
    end
  endtask

  always @(negedge clk) begin
    out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_force;
    if (reset) seen = 1'b0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = result;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result=%h expected none", result);
        end else begin
          m_e = q.pop_front();
          checks++;
          if (result !== m_e.r || zero !== m_e.z || parity !== m_e.p) begin
            errors++;
            $display("FAIL result a=%h b=%h op=%0d: got r=%h z=%b p=%b expected r=%h z=%b p=%b",
                     m_e.a, m_e.b, m_e.op, result, zero, parity, m_e.r, m_e.z, m_e.p);
          end
          chk("latency", 64'(cyc - m_e.acc), 64'd4);
        end
      end else chk("held_result", {32'd0, result}, {32'd0, held});
      if (out_ready) seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && ov2) begin
      if (q2.size() == 0) chk("w64_unexpected", 64'd1, 64'd0);
      else begin
        m2 = q2.pop_front();
        chk("w64_result", r2, m2.r);
        chk("w64_flags", {62'd0, z2, p2}, {62'd0, m2.z, m2.p});
        chk("w64_latency", 64'(cyc - m2.acc), 64'd4);
      end
    end
    if (!reset && ov3) begin
      if (q3.size() == 0) chk("w32s32_unexpected", 64'd1, 64'd0);
      else begin
        m3 = q3.pop_front();
        chk("w32s32_result", {32'd0, r3}, m3.r);
        chk("w32s32_flags", {62'd0, z3, p3}, {62'd0, m3.z, m3.p});
        chk("w32s32_latency", 64'(cyc - m3.acc), 64'd1);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {62'd0, zero, parity}, 64'd0);
    reset = 1'b0;

    @(negedge clk);
    chk("w64_in_ready", {63'd0, rdy2}, 64'd1);
    chk("w32s32_in_ready", {63'd0, rdy3}, 64'd1);
    v2 = 1'b1; op2 = 3'd4;
    v3 = 1'b1; a3 = 32'h12345678; b3 = 32'hFFFFFFFF; op3 = 3'd7;
`ifdef BOOL_SLICE_FLAGS_EN
    q2.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, cyc + 1});
    q3.push_back('{64'h0000_0000_EDCB_A987, 1'b0, 1'b1, cyc + 1});
`else
    q2.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, cyc + 1});
    q3.push_back('{64'h0000_0000_EDCB_A987, 1'b0, 1'b0, cyc + 1});
`endif
    @(negedge clk);
    v2 = 1'b0;
    v3 = 1'b0;

    issue(32'hF0F01234, 32'hFF00FFFF, 3'd0);
    issue(32'hDEADBEEF, 32'hDEADBEEF, 3'd2);
    drain();

    @(posedge clk);
    #1 or_force = 1'b0;
    issue(32'hFFFFFFFF, 32'h0000FFFF, 3'd3);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'h1111_0000 + i;
      op = 3'd1;
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", {32'd0, result}, 64'hFFFF0000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 or_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    drain();

    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h1234_0000;
    b = 32'h0000_5678;
    op = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    issue(32'hAAAAAAAA, 32'h0F0F0F0F, 3'd6);
    drain();

    or_rand = 1'b1;
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 64; y += 9)
        for (int o = 0; o < 8; o++)
          issue(32'(x), 32'(y), 3'(o));
    drain();
    or_rand = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size() + q2.size() + q3.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
